// File: rtl/uart_reg_bank.sv
// uart_reg_bank: NCH independent UART register windows on one DSP bus, with sticky
// W1C interrupt status, masked IRQs and double-buffered baud divisors.
module uart_reg_bank #(
  parameter int DW    = 16,
  parameter int NCH   = 2,
  parameter int CH_AW = 1
) (
  input  logic                DSP_CLK,
  input  logic                RESETn,
  input  logic                DSP_CEn,
  input  logic                DSP_WEn,
  input  logic [CH_AW+4:1]    DSP_ADDR,
  input  logic [DW-1:0]       DSP_WDATA,
  output logic [DW-1:0]       DSP_RDATA,
  output logic [2*NCH-1:0]    Parity,
  output logic [NCH-1:0]      StopBits,
  output logic [3*NCH-1:0]    DataBits,
  output logic [NCH-1:0]      FIFOEn,
  output logic [NCH-1:0]      UARTEn,
  output logic [NCH-1:0]      RxEn,
  output logic [NCH-1:0]      TxEn,
  output logic [4*NCH-1:0]    RxFIFOL,
  output logic [4*NCH-1:0]    TxFIFOL,
  output logic [16*NCH-1:0]   IBRDVal,
  output logic [16*NCH-1:0]   FBRDVal,
  input  logic [NCH-1:0]      ParityError,
  input  logic [NCH-1:0]      FrameError,
  input  logic [NCH-1:0]      OverrunError,
  input  logic [NCH-1:0]      RxFIFO_Empty,
  input  logic [NCH-1:0]      RxFIFO_Full,
  input  logic [NCH-1:0]      TxFIFO_Empty,
  input  logic [NCH-1:0]      TxFIFO_Full,
  output logic [NCH-1:0]      IRQ,
  output logic                DSP_IRQ
);
  logic [CH_AW-1:0] ch;
  logic [3:0]       off;
  logic             wr, rd;
  logic [DW-1:0]    rd_val [NCH];
  logic [DW-1:0]    rd_next;
  logic [NCH-1:0]   irq_next;
  logic             wdata_unused;
  assign ch  = DSP_ADDR[CH_AW+4:5];
  assign off = DSP_ADDR[4:1];
  assign wr  = !DSP_CEn && !DSP_WEn;
  assign rd  = !DSP_CEn && DSP_WEn;
  assign wdata_unused = ^DSP_WDATA;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [15:0] lcr, fcr, cr, ibrd_sh, fbrd_sh, ibrd_act, fbrd_act;
    logic [4:0]  ris, imsc, ris_set, ris_clr;
    logic [3:0]  fr;
    logic        rx_empty_q, tx_empty_q, hit;
    logic [DW-1:0] rv;
    assign hit     = wr && ch == CH_AW'(c);
    assign ris_set = {!tx_empty_q && TxFIFO_Empty[c], rx_empty_q && !RxFIFO_Empty[c],
                      OverrunError[c], FrameError[c], ParityError[c]};
    assign ris_clr = (hit && off == 4'd9) ? DSP_WDATA[4:0] : 5'd0;
    always_ff @(posedge DSP_CLK)
      if (!RESETn) begin
        lcr        <= '0;
        fcr        <= '0;
        cr         <= '0;
        ibrd_sh    <= '0;
        fbrd_sh    <= '0;
        ibrd_act   <= '0;
        fbrd_act   <= '0;
        ris        <= '0;
        imsc       <= '0;
        fr         <= '0;
        rx_empty_q <= 1'b0;
        tx_empty_q <= 1'b0;
      end else begin
        fr         <= {TxFIFO_Full[c], TxFIFO_Empty[c], RxFIFO_Full[c], RxFIFO_Empty[c]};
        rx_empty_q <= RxFIFO_Empty[c];
        tx_empty_q <= TxFIFO_Empty[c];
        ris        <= (ris & ~ris_clr) | ris_set;
        if (hit && off == 4'd1) lcr <= DSP_WDATA[15:0];
        if (hit && off == 4'd2) fcr <= DSP_WDATA[15:0];
        if (hit && off == 4'd3) cr <= DSP_WDATA[15:0];
        if (hit && off == 4'd6) imsc <= DSP_WDATA[4:0];
        if (hit && off == 4'd7) ibrd_sh <= DSP_WDATA[15:0];
        if (hit && off == 4'd8) fbrd_sh <= DSP_WDATA[15:0];
        // commit uses the shadow values as they stood before this edge
        if (hit && off == 4'd11) begin
          ibrd_act <= ibrd_sh;
          fbrd_act <= fbrd_sh;
        end
      end
    always_comb
      case (off)
        4'd1:    rv = DW'(lcr);
        4'd2:    rv = DW'(fcr);
        4'd3:    rv = DW'(cr);
        4'd4:    rv = DW'({fr, 4'h0});
        4'd5:    rv = DW'(ris);
        4'd6:    rv = DW'(imsc);
        4'd7:    rv = DW'(ibrd_sh);
        4'd8:    rv = DW'(fbrd_sh);
        4'd10:   rv = DW'(ris & imsc);
        default: rv = '0;
      endcase
    assign rd_val[c]          = rv;
    assign irq_next[c]        = |(ris & imsc);
    assign Parity[2*c+:2]     = lcr[1:0];
    assign StopBits[c]        = lcr[2];
    assign DataBits[3*c+:3]   = {1'b1, lcr[4:3]};
    assign FIFOEn[c]          = lcr[5];
    assign UARTEn[c]          = cr[0];
    assign RxEn[c]            = cr[1];
    assign TxEn[c]            = cr[2];
    assign RxFIFOL[4*c+:4]    = fcr[3:0];
    assign TxFIFOL[4*c+:4]    = fcr[7:4];
    assign IBRDVal[16*c+:16]  = ibrd_act;
    assign FBRDVal[16*c+:16]  = fbrd_act;
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NCH; i++) rd_next = (ch == CH_AW'(i)) ? rd_val[i] : rd_next;
  end

  always_ff @(posedge DSP_CLK)
    if (!RESETn) begin
      DSP_RDATA <= '0;
      IRQ       <= '0;
      DSP_IRQ   <= 1'b0;
    end else begin
      if (rd) DSP_RDATA <= rd_next;
      IRQ     <= irq_next;
      DSP_IRQ <= |irq_next;
    end
endmodule

// File: tb/tb_uart_reg_bank.sv
// tb_uart_reg_bank: directed stimulus against an offset-indexed behavioural model,
// checked every cycle, plus hand-computed literal expectations.
module tb_uart_reg_bank;
  localparam int DW = 32, NCH = 2, CH_AW = 2;
  logic DSP_CLK = 0, RESETn = 0, DSP_CEn = 1, DSP_WEn = 1;
  logic [CH_AW+4:1] DSP_ADDR = '0;
  logic [DW-1:0] DSP_WDATA = '0, DSP_RDATA;
  logic [2*NCH-1:0] Parity;
  logic [NCH-1:0] StopBits, FIFOEn, UARTEn, RxEn, TxEn, IRQ;
  logic [3*NCH-1:0] DataBits;
  logic [4*NCH-1:0] RxFIFOL, TxFIFOL;
  logic [16*NCH-1:0] IBRDVal, FBRDVal;
  logic [NCH-1:0] ParityError = '0, FrameError = '0, OverrunError = '0;
  logic [NCH-1:0] RxFIFO_Empty = 2'b11, RxFIFO_Full = 2'b10, TxFIFO_Empty = 2'b00, TxFIFO_Full = 2'b00;
  logic DSP_IRQ;
  int n_cmp = 0, n_bad = 0;

  uart_reg_bank #(.DW(DW), .NCH(NCH), .CH_AW(CH_AW)) dut (
    .DSP_CLK(DSP_CLK), .RESETn(RESETn), .DSP_CEn(DSP_CEn), .DSP_WEn(DSP_WEn),
    .DSP_ADDR(DSP_ADDR), .DSP_WDATA(DSP_WDATA), .DSP_RDATA(DSP_RDATA),
    .Parity(Parity), .StopBits(StopBits), .DataBits(DataBits), .FIFOEn(FIFOEn),
    .UARTEn(UARTEn), .RxEn(RxEn), .TxEn(TxEn), .RxFIFOL(RxFIFOL), .TxFIFOL(TxFIFOL),
    .IBRDVal(IBRDVal), .FBRDVal(FBRDVal), .ParityError(ParityError),
    .FrameError(FrameError), .OverrunError(OverrunError), .RxFIFO_Empty(RxFIFO_Empty),
    .RxFIFO_Full(RxFIFO_Full), .TxFIFO_Empty(TxFIFO_Empty), .TxFIFO_Full(TxFIFO_Full),
    .IRQ(IRQ), .DSP_IRQ(DSP_IRQ));

  always #5 DSP_CLK = ~DSP_CLK;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // model state: m_reg[ch][offset] holds every RW register by its bus offset
  logic [15:0] m_reg [NCH][16];
  logic [4:0]  m_ris [NCH];
  logic [3:0]  m_fr [NCH];
  logic        m_rxq [NCH], m_txq [NCH];
  logic [15:0] m_ibrd [NCH], m_fbrd [NCH];
  logic [NCH-1:0] m_irq;
  logic        m_dirq;
  logic [DW-1:0] m_rdata;
  bit          model_valid = 0;
  int          mch, moff;
  logic        mwr, mrd;
  logic [4:0]  mset, mclr;

  function automatic logic [DW-1:0] mread(input int c, input int o);
    if (c >= NCH) return '0;
    case (o)
      1, 2, 3, 6, 7, 8: return DW'(m_reg[c][o]);
      4:  return DW'({m_fr[c], 4'h0});
      5:  return DW'(m_ris[c]);
      10: return DW'(m_ris[c] & m_reg[c][6][4:0]);
      default: return '0;
    endcase
  endfunction

  always @(posedge DSP_CLK) begin
    mch = int'(DSP_ADDR[6:5]);
    moff = int'(DSP_ADDR[4:1]);
    mwr = !DSP_CEn && !DSP_WEn;
    mrd = !DSP_CEn && DSP_WEn;
    if (!RESETn) begin
      for (int c = 0; c < NCH; c++) begin
        for (int o = 0; o < 16; o++) m_reg[c][o] = '0;
        m_ris[c] = '0; m_fr[c] = '0; m_rxq[c] = 0; m_txq[c] = 0;
        m_ibrd[c] = '0; m_fbrd[c] = '0;
      end
      m_irq = '0; m_dirq = 0; m_rdata = '0; model_valid = 1;
    end else begin
      if (mrd) m_rdata = mread(mch, moff);
      for (int c = 0; c < NCH; c++) m_irq[c] = |(m_ris[c] & m_reg[c][6][4:0]);
      m_dirq = |m_irq;
      for (int c = 0; c < NCH; c++) begin
        mset = {!m_txq[c] && TxFIFO_Empty[c], m_rxq[c] && !RxFIFO_Empty[c],
                OverrunError[c], FrameError[c], ParityError[c]};
        mclr = (mwr && mch == c && moff == 9) ? DSP_WDATA[4:0] : 5'd0;
        m_ris[c] = (m_ris[c] & ~mclr) | mset;
        m_rxq[c] = RxFIFO_Empty[c];
        m_txq[c] = TxFIFO_Empty[c];
        m_fr[c] = {TxFIFO_Full[c], TxFIFO_Empty[c], RxFIFO_Full[c], RxFIFO_Empty[c]};
        if (mwr && mch == c && moff == 11) begin
          m_ibrd[c] = m_reg[c][7];
          m_fbrd[c] = m_reg[c][8];
        end
      end
      if (mwr && mch < NCH && (moff inside {1, 2, 3, 7, 8})) m_reg[mch][moff] = DSP_WDATA[15:0];
      if (mwr && mch < NCH && moff == 6) m_reg[mch][6] = 16'(DSP_WDATA[4:0]);
    end
  end

  logic [2*NCH-1:0] e_par;
  logic [NCH-1:0] e_stop, e_fen, e_uen, e_rxen, e_txen;
  logic [3*NCH-1:0] e_db;
  logic [4*NCH-1:0] e_rxl, e_txl;
  logic [16*NCH-1:0] e_ibrd, e_fbrd;

  always @(negedge DSP_CLK) if (model_valid) begin
    for (int c = 0; c < NCH; c++) begin
      e_par[2*c+:2] = m_reg[c][1][1:0];
      e_stop[c] = m_reg[c][1][2];
      e_db[3*c+:3] = 3'd4 + 3'(m_reg[c][1][4:3]);
      e_fen[c] = m_reg[c][1][5];
      e_uen[c] = m_reg[c][3][0];
      e_rxen[c] = m_reg[c][3][1];
      e_txen[c] = m_reg[c][3][2];
      e_rxl[4*c+:4] = m_reg[c][2][3:0];
      e_txl[4*c+:4] = m_reg[c][2][7:4];
      e_ibrd[16*c+:16] = m_ibrd[c];
      e_fbrd[16*c+:16] = m_fbrd[c];
    end
    chk("m_rdata", 64'(DSP_RDATA), 64'(m_rdata));
    chk("m_lcr", 64'({Parity, StopBits, DataBits, FIFOEn}), 64'({e_par, e_stop, e_db, e_fen}));
    chk("m_cr_fcr", 64'({UARTEn, RxEn, TxEn, RxFIFOL, TxFIFOL}), 64'({e_uen, e_rxen, e_txen, e_rxl, e_txl}));
    chk("m_brd", {IBRDVal, FBRDVal}, {e_ibrd, e_fbrd});
    chk("m_irq", 64'({IRQ, DSP_IRQ}), 64'({m_irq, m_dirq}));
  end

  task automatic wr(input int c, input int o, input logic [DW-1:0] d);
    @(negedge DSP_CLK);
    DSP_CEn = 0; DSP_WEn = 0; DSP_ADDR = 6'(c * 16 + o); DSP_WDATA = d;
    @(negedge DSP_CLK);
    DSP_CEn = 1; DSP_WEn = 1;
  endtask

  task automatic rdchk(input int c, input int o, input logic [DW-1:0] e, input string n);
    @(negedge DSP_CLK);
    DSP_CEn = 0; DSP_WEn = 1; DSP_ADDR = 6'(c * 16 + o);
    @(negedge DSP_CLK);
    DSP_CEn = 1;
    chk(n, 64'(DSP_RDATA), 64'(e));
  endtask

  initial begin
    repeat (3) @(negedge DSP_CLK);
    RESETn = 1;
    @(negedge DSP_CLK);
    chk("databits_rst", 64'(DataBits), 64'(6'b100100));
    chk("irq_rst", 64'({IRQ, DSP_IRQ}), 64'(0));
    for (int c = 0; c < NCH; c++)
      for (int o = 1; o <= 11; o++)
        rdchk(c, o, (o == 4) ? ((c == 0) ? 32'h10 : 32'h30) : 32'h0, $sformatf("rst_rd_c%0d_o%0d", c, o));
    wr(1, 1, 32'hFFFF_003B);
    chk("lcr1_out", 64'({Parity, StopBits, DataBits, FIFOEn}), 64'({4'b1100, 2'b00, 6'b111100, 2'b10}));
    rdchk(1, 1, 32'h003B, "lcr1_rd");
    wr(0, 7, 32'h0100);
    chk("ibrd_shadow_only", 64'(IBRDVal), 64'(0));
    wr(0, 11, 32'h0);
    chk("ibrd_commit", 64'(IBRDVal), 64'(32'h0000_0100));
    wr(0, 7, 32'h0200);
    chk("ibrd_hold", 64'(IBRDVal), 64'(32'h0000_0100));
    wr(0, 11, 32'h0);
    chk("ibrd_commit2", 64'(IBRDVal), 64'(32'h0000_0200));
    wr(1, 8, 32'h0015);
    wr(1, 11, 32'h0);
    chk("fbrd_commit", 64'(FBRDVal), 64'(32'h0015_0000));
    wr(0, 6, 32'h02);
    @(negedge DSP_CLK); FrameError = 2'b01;
    @(negedge DSP_CLK); FrameError = 2'b00;
    chk("irq_lag", 64'({IRQ, DSP_IRQ}), 64'(0));
    @(negedge DSP_CLK);
    chk("irq_set", 64'({IRQ, DSP_IRQ}), 64'(3'b011));
    rdchk(0, 5, 32'h02, "ris_frame");
    rdchk(0, 10, 32'h02, "mis_frame");
    wr(0, 9, 32'h02);
    chk("irq_hold_after_icr", 64'(IRQ), 64'(2'b01));
    @(negedge DSP_CLK);
    chk("irq_clear", 64'({IRQ, DSP_IRQ}), 64'(0));
    rdchk(0, 5, 32'h0, "ris_cleared");
    @(negedge DSP_CLK);
    DSP_CEn = 0; DSP_WEn = 0; DSP_ADDR = 6'(9); DSP_WDATA = 32'h1; ParityError = 2'b01;
    @(negedge DSP_CLK);
    DSP_CEn = 1; DSP_WEn = 1; ParityError = 2'b00;
    rdchk(0, 5, 32'h01, "set_beats_clear");
    wr(0, 9, 32'h1);
    rdchk(0, 5, 32'h0, "parity_cleared");
    @(negedge DSP_CLK); RxFIFO_Empty[0] = 0; TxFIFO_Empty[1] = 1;
    wr(1, 6, 32'h10);
    rdchk(0, 5, 32'h08, "ris_rx_edge");
    rdchk(1, 5, 32'h10, "ris_tx_edge");
    chk("irq_ch1", 64'({IRQ, DSP_IRQ}), 64'(3'b101));
    wr(0, 12, 32'hFFFF_FFFF);
    wr(3, 1, 32'hFFFF_FFFF);
    wr(2, 3, 32'hFFFF_FFFF);
    chk("unmapped_no_effect", 64'({Parity, UARTEn}), 64'({4'b1100, 2'b00}));
    rdchk(0, 12, 32'h0, "rd_off12");
    rdchk(3, 1, 32'h0, "rd_ch3");
    rdchk(0, 0, 32'h0, "rd_off0");
    rdchk(0, 9, 32'h0, "rd_icr");
    rdchk(0, 11, 32'h0, "rd_brdupd");
    rdchk(1, 1, 32'h003B, "lcr1_rd2");
    @(negedge DSP_CLK);
    DSP_CEn = 0; DSP_WEn = 1; DSP_ADDR = 6'(17); RESETn = 0;
    @(negedge DSP_CLK);
    chk("rst_rdata", 64'(DSP_RDATA), 64'(0));
    chk("rst_outs", 64'({DataBits, IRQ, DSP_IRQ, Parity}), 64'({6'b100100, 3'b000, 4'b0000}));
    chk("rst_brd", {IBRDVal, FBRDVal}, 64'(0));
    RESETn = 1; DSP_CEn = 1;
    repeat (3) @(negedge DSP_CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
